// File: rtl/reaction_round_ctrl.sv
// Reaction-timer round sequencer: arm, wait, GO lamp, ms count, result strobe.
// Optional feature macro RAND_DELAY_EN adds an LFSR-based random extra wait.
module reaction_round_ctrl #(
    parameter int TICK_DIV     = 50000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_MASK    = 4095,
    parameter int TIMEOUT_MS   = 9999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_start,
    input  logic        btn_react,
    output logic        led_go,
    output logic [23:0] timecount,
    output logic        result_valid,
    output logic        false_start,
    output logic        timeout,
    output logic        busy
);

    localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_WAIT  = 3'd2,
        S_GO    = 3'd3,
        S_DONE  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_start_sync;
    logic [2:0]         r_react_sync;
    logic [DIV_W-1:0]   r_div;
    logic [DIV_W-1:0]   w_div_nxt;
    logic [15:0]        r_delay;
    logic [15:0]        w_delay_nxt;
    logic [15:0]        w_delay_load;
    logic [23:0]        r_tc;
    logic [23:0]        w_tc_nxt;
    logic               r_rv;
    logic               w_rv_nxt;
    logic               r_fs;
    logic               w_fs_nxt;
    logic               r_to;
    logic               w_to_nxt;
    logic               r_led_go;
    logic               r_busy;
    logic               w_start_edge;
    logic               w_react_edge;
    logic               w_timing;
    logic               w_tick;

    // Bit 0/1 form the synchroniser, bit 2 is history for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_sync <= 3'b000;
            r_react_sync <= 3'b000;
        end else begin
            r_start_sync <= {r_start_sync[1:0], btn_start};
            r_react_sync <= {r_react_sync[1:0], btn_react};
        end
    end

    assign w_start_edge = r_start_sync[1] & ~r_start_sync[2];
    assign w_react_edge = r_react_sync[1] & ~r_react_sync[2];
    assign w_timing     = (r_state == S_WAIT) || (r_state == S_GO);
    assign w_tick       = w_timing && (r_div == DIV_W'(TICK_DIV - 1));

`ifdef RAND_DELAY_EN
    logic [15:0] r_lfsr;

    // Free-running Fibonacci LFSR, taps 16,14,13,11
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_delay_load = 16'(MIN_DELAY_MS) + (r_lfsr & 16'(RAND_MASK));
`else
    assign w_delay_load = 16'(MIN_DELAY_MS);
`endif

    // Next-state and next-datapath decode; react beats expiry/timeout, start beats react
    always_comb begin
        w_state_nxt = r_state;
        w_delay_nxt = r_delay;
        w_tc_nxt    = r_tc;
        w_rv_nxt    = 1'b0;
        w_fs_nxt    = r_fs;
        w_to_nxt    = r_to;
        case (r_state)
            S_IDLE, S_DONE, S_FAULT: begin
                if (w_start_edge) begin
                    w_state_nxt = S_ARM;
                    w_tc_nxt    = 24'd0;
                    w_fs_nxt    = 1'b0;
                    w_to_nxt    = 1'b0;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_ARM: begin
                w_state_nxt = S_WAIT;
                w_delay_nxt = w_delay_load;
                w_tc_nxt    = 24'd0;
                w_fs_nxt    = 1'b0;
                w_to_nxt    = 1'b0;
            end
            S_WAIT: begin
                if (w_react_edge) begin
                    w_state_nxt = S_FAULT;
                    w_fs_nxt    = 1'b1;
                    w_tc_nxt    = 24'd0;
                end else if (w_tick) begin
                    if (r_delay <= 16'd1) begin
                        w_state_nxt = S_GO;
                        w_tc_nxt    = 24'd0;
                    end else begin
                        w_delay_nxt = r_delay - 16'd1;
                    end
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_GO: begin
                if (w_react_edge) begin
                    w_state_nxt = S_DONE;
                    w_tc_nxt    = (r_tc == 24'd0) ? 24'd1 : r_tc;
                    w_rv_nxt    = 1'b1;
                end else if (w_tick) begin
                    if ((r_tc + 24'd1) == 24'(TIMEOUT_MS)) begin
                        w_state_nxt = S_DONE;
                        w_to_nxt    = 1'b1;
                        w_tc_nxt    = 24'd0;
                    end else begin
                        w_tc_nxt = r_tc + 24'd1;
                    end
                end else begin
                    w_state_nxt = S_GO;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tc_nxt    = 24'd0;
                w_fs_nxt    = 1'b0;
                w_to_nxt    = 1'b0;
            end
        endcase
        if (w_timing && (w_state_nxt == r_state) && !w_tick) begin
            w_div_nxt = r_div + DIV_W'(1);
        end else begin
            w_div_nxt = '0;
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_div    <= '0;
            r_delay  <= 16'd0;
            r_tc     <= 24'd0;
            r_rv     <= 1'b0;
            r_fs     <= 1'b0;
            r_to     <= 1'b0;
            r_led_go <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_div    <= w_div_nxt;
            r_delay  <= w_delay_nxt;
            r_tc     <= w_tc_nxt;
            r_rv     <= w_rv_nxt;
            r_fs     <= w_fs_nxt;
            r_to     <= w_to_nxt;
            r_led_go <= (w_state_nxt == S_GO);
            r_busy   <= (w_state_nxt == S_ARM) || (w_state_nxt == S_WAIT) ||
                        (w_state_nxt == S_GO);
        end
    end

    assign led_go       = r_led_go;
    assign timecount    = r_tc;
    assign result_valid = r_rv;
    assign false_start  = r_fs;
    assign timeout      = r_to;
    assign busy         = r_busy;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Directed bench for reaction_round_ctrl with TICK_DIV=4, MIN_DELAY_MS=3, TIMEOUT_MS=20.
module tb_reaction_round_ctrl;

    logic        clk;
    logic        rst_n;
    logic        btn_start;
    logic        btn_react;
    logic        led_go;
    logic [23:0] timecount;
    logic        result_valid;
    logic        false_start;
    logic        timeout;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int rv_cnt   = 0;
    bit led_seen = 1'b0;
    int cyc;

    reaction_round_ctrl #(
        .TICK_DIV     (4),
        .MIN_DELAY_MS (3),
        .RAND_MASK    (4095),
        .TIMEOUT_MS   (20)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_start    (btn_start),
        .btn_react    (btn_react),
        .led_go       (led_go),
        .timecount    (timecount),
        .result_valid (result_valid),
        .false_start  (false_start),
        .timeout      (timeout),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count strobes and GO-lamp activity between posedges
    always @(negedge clk) begin
        if (result_valid) rv_cnt = rv_cnt + 1;
        if (led_go) led_seen = 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        btn_start = 1'b1;
        step(1);
        btn_start = 1'b0;
    endtask

    task automatic pulse_react();
        btn_react = 1'b1;
        step(1);
        btn_react = 1'b0;
    endtask

    // Returns cycles from start pin to led_go, counting the pulse cycle
    task automatic start_and_wait_go(output int c);
        pulse_start();
        c = 1;
        while (!led_go && c < 200) begin
            step(1);
            c = c + 1;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        btn_start = 1'b0;
        btn_react = 1'b0;
        step(3);
        check_eq("rst_led_go", 32'(led_go), 32'd0);
        check_eq("rst_timecount", 32'(timecount), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_false_start", 32'(false_start), 32'd0);
        rst_n = 1'b1;
        step(2);

        // Round 1: react with 10 ms on the clock
        rv_cnt = 0;
        start_and_wait_go(cyc);
        check_eq("go_latency", 32'(cyc), 32'd16);
        check_eq("go_busy", 32'(busy), 32'd1);
        check_eq("go_tc_start", 32'(timecount), 32'd0);
        step(39);
        pulse_react();
        step(2);
        check_eq("r1_result_valid", 32'(result_valid), 32'd1);
        check_eq("r1_timecount", 32'(timecount), 32'd10);
        check_eq("r1_led_go", 32'(led_go), 32'd0);
        step(1);
        check_eq("r1_rv_drop", 32'(result_valid), 32'd0);
        step(10);
        check_eq("r1_tc_hold", 32'(timecount), 32'd10);
        check_eq("r1_rv_count", 32'(rv_cnt), 32'd1);

        // Round 2: react during WAIT
        rv_cnt   = 0;
        led_seen = 1'b0;
        pulse_start();
        step(5);
        pulse_react();
        step(5);
        check_eq("r2_false_start", 32'(false_start), 32'd1);
        check_eq("r2_timecount", 32'(timecount), 32'd0);
        check_eq("r2_busy", 32'(busy), 32'd0);
        step(30);
        check_eq("r2_led_seen", 32'(led_seen), 32'd0);
        check_eq("r2_rv_count", 32'(rv_cnt), 32'd0);

        // Round 3: react edge coincides with the expiry tick
        led_seen = 1'b0;
        pulse_start();
        step(12);
        pulse_react();
        step(30);
        check_eq("r3_false_start", 32'(false_start), 32'd1);
        check_eq("r3_led_seen", 32'(led_seen), 32'd0);

        // Round 4: start from FAULT clears flags, then fast react
        rv_cnt = 0;
        pulse_start();
        step(2);
        check_eq("r4_arm_busy", 32'(busy), 32'd1);
        check_eq("r4_arm_fs", 32'(false_start), 32'd0);
        cyc = 3;
        while (!led_go && cyc < 200) begin
            step(1);
            cyc = cyc + 1;
        end
        check_eq("r4_go_latency", 32'(cyc), 32'd16);
        pulse_react();
        step(2);
        check_eq("r4_result_valid", 32'(result_valid), 32'd1);
        check_eq("r4_timecount_min", 32'(timecount), 32'd1);

        // Round 5: restart from DONE, then let it time out
        pulse_start();
        step(2);
        check_eq("r5_arm_busy", 32'(busy), 32'd1);
        check_eq("r5_arm_tc", 32'(timecount), 32'd0);
        rv_cnt = 0;
        cyc = 3;
        while (!led_go && cyc < 200) begin
            step(1);
            cyc = cyc + 1;
        end
        cyc = 0;
        while (!timeout && cyc < 300) begin
            step(1);
            cyc = cyc + 1;
        end
        check_eq("r5_timeout_cycles", 32'(cyc), 32'd80);
        check_eq("r5_timeout", 32'(timeout), 32'd1);
        check_eq("r5_timecount", 32'(timecount), 32'd0);
        check_eq("r5_led_go", 32'(led_go), 32'd0);
        check_eq("r5_rv_count", 32'(rv_cnt), 32'd0);

        // Round 6: asynchronous reset in the middle of GO
        start_and_wait_go(cyc);
        check_eq("r6_go_reached", 32'(led_go), 32'd1);
        step(5);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("r6_rst_led_go", 32'(led_go), 32'd0);
        check_eq("r6_rst_busy", 32'(busy), 32'd0);
        check_eq("r6_rst_tc", 32'(timecount), 32'd0);
        check_eq("r6_rst_flags", 32'({result_valid, false_start, timeout}), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(2);
        pulse_start();
        step(2);
        check_eq("r6_arm_after_rst", 32'(busy), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
